jump_encoder: RTL and testbench

Inverse of the `Jump_Shift` datapath step in the single-cycle processor. The block accepts a 32-bit jump target and the current PC+4, then produces the 26-bit J-type address field and the 4-bit upper-PC remainder. It also flags targets that are misaligned or outside the current 256 MB region. Requests and results are buffered in a small FIFO behind valid/ready handshakes, so it can sit between an assembler/loader front-end or trace source and downstream instruction-build logic.

---
 rtl/jump_encoder.sv | 173 +++++++++++++++++
 tb/tb_jump_encoder.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/jump_encoder.sv
// jump_encoder: inverse of the Jump_Shift datapath step.
// Splits a 32-bit jump target into the 26-bit J-type address field and the
// 4-bit upper-PC remainder. It flags misaligned targets and targets outside
// the 256 MB region of PC+4. Results sit in a small FIFO behind valid/ready
// handshakes on both sides.
// Optional feature: define JUMP_ENC_ERRCNT_EN to build the saturating error
// counter. Without it, err_count is tied to zero.
module jump_encoder #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      target,
    input  logic [31:0]      pc_plus4,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [25:0]      adr,
    output logic [3:0]       adr_rmdr,
    output logic             err_align,
    output logic             err_region,
    output logic [CNT_W-1:0] enc_count,
    output logic [7:0]       err_count
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OCC_W = PTR_W + 1;

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(FIFO_DEPTH);
    localparam logic [OCC_W-1:0] OCC_LAST = OCC_W'(FIFO_DEPTH - 1);
    localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);

    // One encoded result, as stored per FIFO slot
    typedef struct packed {
        logic [25:0] adr;
        logic [3:0]  rmdr;
        logic        ealign;
        logic        eregion;
    } entry_t;

    typedef enum logic [1:0] {
        S_EMPTY   = 2'd0,
        S_PARTIAL = 2'd1,
        S_FULL    = 2'd2
    } state_t;

    entry_t             r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wptr;
    logic [PTR_W-1:0]   r_rptr;
    logic [OCC_W-1:0]   r_count;
    state_t             r_state;
    logic [CNT_W-1:0]   r_enc_cnt;

    logic               w_in_ready;
    logic               w_out_valid;
    logic               w_push;
    logic               w_pop;
    entry_t             w_new;
    entry_t             w_head;
    logic               w_unused_pc;

    // Ready and valid depend only on registered state.
    // There is no combinational path from out_ready to in_ready.
    assign w_in_ready  = (r_state != S_FULL);
    assign w_out_valid = (r_state != S_EMPTY);
    assign w_push      = in_valid && w_in_ready;
    assign w_pop       = w_out_valid && out_ready;

    // Encode on the input side so each slot holds a finished result
    always_comb begin
        w_new         = '0;
        w_new.adr     = target[27:2];
        w_new.rmdr    = target[31:28];
        w_new.ealign  = |target[1:0];
        w_new.eregion = (target[31:28] != pc_plus4[31:28]);
    end

    // Only the region nibble of PC+4 matters for the encoding
    assign w_unused_pc = ^pc_plus4[27:0];

    // Storage array. Stale slots are never visible because the head is gated by out_valid
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= w_new;
        end
    end

    // Pointers, occupancy and the EMPTY/PARTIAL/FULL control state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_state <= S_EMPTY;
        end else begin
            if (w_push) begin
                r_wptr <= (r_wptr == PTR_LAST) ? '0 : r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == PTR_LAST) ? '0 : r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            case (r_state)
                S_EMPTY: begin
                    // A pop is impossible while empty
                    if (w_push) begin
                        r_state <= (OCC_ONE == OCC_FULL) ? S_FULL : S_PARTIAL;
                    end
                end
                S_PARTIAL: begin
                    if (w_push && !w_pop && (r_count == OCC_LAST)) begin
                        r_state <= S_FULL;
                    end else if (w_pop && !w_push && (r_count == OCC_ONE)) begin
                        r_state <= S_EMPTY;
                    end
                end
                S_FULL: begin
                    // A push is impossible while full
                    if (w_pop) begin
                        r_state <= (OCC_LAST == '0) ? S_EMPTY : S_PARTIAL;
                    end
                end
                default: r_state <= S_EMPTY;
            endcase
        end
    end

    // Head entry, forced to zero while empty so reset shows clean outputs
    assign w_head = w_out_valid ? r_mem[r_rptr] : '0;

    assign in_ready   = w_in_ready;
    assign out_valid  = w_out_valid;
    assign adr        = w_head.adr;
    assign adr_rmdr   = w_head.rmdr;
    assign err_align  = w_head.ealign;
    assign err_region = w_head.eregion;

    // Count results taken by the consumer. Wraps naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_enc_cnt <= '0;
        end else if (w_pop) begin
            r_enc_cnt <= r_enc_cnt + 1'b1;
        end
    end

    assign enc_count = r_enc_cnt;

`ifdef JUMP_ENC_ERRCNT_EN
    logic [7:0] r_err_cnt;

    // Count erroneous results taken by the consumer. Saturates at 255
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= '0;
        end else if (w_pop && (w_head.ealign || w_head.eregion) && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 1'b1;
        end
    end

    assign err_count = r_err_cnt;
`else
    assign err_count = 8'd0;
`endif

endmodule

// File: tb/tb_jump_encoder.sv
// Self-checking bench for jump_encoder.
// The reference model keeps raw requests in a queue.
// Expected fields are computed with plain arithmetic when an entry reaches the head.
module tb_jump_encoder;

    localparam int DEPTH = 4;
    localparam int CNT_W = 16;
`ifdef JUMP_ENC_ERRCNT_EN
    localparam bit ERRCNT = 1'b1;
`else
    localparam bit ERRCNT = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [31:0]      target = '0;
    logic [31:0]      pc_plus4 = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [25:0]      adr;
    logic [3:0]       adr_rmdr;
    logic             err_align;
    logic             err_region;
    logic [CNT_W-1:0] enc_count;
    logic [7:0]       err_count;

    jump_encoder #(.FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .target(target), .pc_plus4(pc_plus4),
        .out_valid(out_valid), .out_ready(out_ready),
        .adr(adr), .adr_rmdr(adr_rmdr),
        .err_align(err_align), .err_region(err_region),
        .enc_count(enc_count), .err_count(err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] t;
        logic [31:0] pc;
    } req_t;

    req_t q[$];
    int   exp_enc = 0;
    int   exp_err = 0;
    int   checks  = 0;
    int   errors  = 0;

    function automatic bit is_err(input req_t r);
        return ((r.t % 4) != 0) || ((r.t / 32'h1000_0000) != (r.pc / 32'h1000_0000));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        req_t h;
        chk("in_ready", 32'(in_ready), 32'(q.size() != DEPTH));
        chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            h = q[0];
            chk("adr", 32'(adr), (h.t / 4) % 32'h0400_0000);
            chk("adr_rmdr", 32'(adr_rmdr), h.t / 32'h1000_0000);
            chk("err_align", 32'(err_align), 32'((h.t % 4) != 0));
            chk("err_region", 32'(err_region),
                32'((h.t / 32'h1000_0000) != (h.pc / 32'h1000_0000)));
            // Round trip: Jump_Shift(adr, rmdr) rebuilds the word-aligned target
            chk("round_trip", {adr_rmdr, adr, 2'b00}, h.t - (h.t % 4));
        end
        chk("enc_count", 32'(enc_count), exp_enc % 65536);
        chk("err_count", 32'(err_count), exp_err);
    endtask

    // One clock: check at negedge, apply handshake to the model at posedge
    task automatic cycle();
        bit   push, pop;
        req_t r, h;
        @(negedge clk);
        check_outputs();
        push = in_valid && (q.size() != DEPTH);
        pop  = out_ready && (q.size() != 0);
        r.t  = target;
        r.pc = pc_plus4;
        @(posedge clk);
        if (pop) begin
            h = q.pop_front();
            exp_enc++;
            if (ERRCNT && is_err(h) && exp_err < 255) exp_err++;
        end
        if (push) q.push_back(r);
        #1;
    endtask

    task automatic rand_req(input bit force_err);
        logic [31:0] t, pc;
        t  = $urandom;
        pc = $urandom;
        if ($urandom_range(0, 3) != 0) pc[31:28] = t[31:28];
        if ($urandom_range(0, 1) != 0 && !force_err) t[1:0] = 2'b00;
        if (force_err && t[1:0] == 2'b00) t[0] = 1'b1;
        target   = t;
        pc_plus4 = pc;
    endtask

    int enc0;

    initial begin
        // Reset values
        #12;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_adr", 32'(adr), 32'd0);
        chk("rst_rmdr", 32'(adr_rmdr), 32'd0);
        chk("rst_errs", {30'd0, err_align, err_region}, 32'd0);
        chk("rst_enc", 32'(enc_count), 32'd0);
        chk("rst_errcnt", 32'(err_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Aligned in-region target
        target = 32'h0040_0010; pc_plus4 = 32'h0040_0004;
        in_valid = 1'b1; out_ready = 1'b1;
        cycle();
        in_valid = 1'b0;
        chk("tp1_valid", 32'(out_valid), 32'd1);
        chk("tp1_adr", 32'(adr), 32'h0100004);
        chk("tp1_rmdr", 32'(adr_rmdr), 32'h0);
        chk("tp1_errs", {30'd0, err_align, err_region}, 32'd0);
        cycle();
        chk("tp1_enc", 32'(enc_count), 32'd1);

        // Misaligned target
        target = 32'h0040_0012; in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        chk("tp2_adr", 32'(adr), 32'h0100004);
        chk("tp2_align", 32'(err_align), 32'd1);
        chk("tp2_region", 32'(err_region), 32'd0);
        cycle();
        chk("tp2_errcnt", 32'(err_count), ERRCNT ? 32'd1 : 32'd0);

        // Out-of-region target
        target = 32'h1000_0000; in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        chk("tp3_adr", 32'(adr), 32'h0);
        chk("tp3_rmdr", 32'(adr_rmdr), 32'h1);
        chk("tp3_region", 32'(err_region), 32'd1);
        cycle();

        // Fill to full with the consumer stalled, drain in order, then repeat to exercise the wrap
        for (int rnd = 0; rnd < 2; rnd++) begin
            out_ready = 1'b0; in_valid = 1'b1;
            for (int i = 0; i < 5; i++) begin
                target = 32'h0040_0100 + 32'(rnd * 64 + i * 4);
                cycle();
                if (i == 3) chk("full_in_ready", 32'(in_ready), 32'd0);
            end
            in_valid = 1'b0; out_ready = 1'b1;
            for (int i = 0; i < 4; i++) cycle();
            chk("drained", 32'(out_valid), 32'd0);
        end

        // Streaming: one push and one pop every cycle
        enc0 = int'(enc_count);
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            target = 32'h0040_1000 + 32'(i * 4);
            cycle();
            chk("stream_occ1", {30'd0, out_valid, in_ready}, 32'd3);
        end
        chk("stream_enc", 32'(enc_count), 32'(enc0 + 19));
        in_valid = 1'b0;
        cycle();

        // Asynchronous reset with three entries buffered
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_req(1'b0);
            cycle();
        end
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        chk("arst_adr", 32'(adr), 32'd0);
        chk("arst_enc", 32'(enc_count), 32'd0);
        chk("arst_errcnt", 32'(err_count), 32'd0);
        q.delete();
        exp_enc = 0;
        exp_err = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Saturate the error counter with erroneous results
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 261; i++) begin
            rand_req(1'b1);
            cycle();
        end
        chk("sat_errcnt", 32'(err_count), ERRCNT ? 32'd255 : 32'd0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            rand_req(1'b0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            cycle();
        end

        // Drain
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) cycle();
        chk("final_empty", 32'(out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
